// File: rtl/bias_requant_relu.sv
// Bias add, rounding requantization shift, optional ReLU and saturation
// for the accumulator stream leaving the pointwise multiplier.
module bias_requant_relu #(
    parameter int IN_WIDTH   = 24,
    parameter int DATA_WIDTH = 8,
    parameter int BIAS_NUM   = 16,
    parameter int BIAS_WIDTH = 24,
    parameter int SHIFT      = 4,
    parameter int RELU       = 1,
    localparam int AW = (BIAS_NUM > 1) ? $clog2(BIAS_NUM) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         valid_i,
    input  logic signed [IN_WIDTH-1:0]   data_i,
    input  logic                         sop_i,
    input  logic                         eop_i,
    input  logic                         sof_i,
    input  logic                         eof_i,
    input  logic                         bias_wr_i,
    input  logic [AW-1:0]                bias_addr_i,
    input  logic signed [BIAS_WIDTH-1:0] bias_data_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         data_valid_o,
    output logic                         sop_o,
    output logic                         eop_o,
    output logic                         sof_o,
    output logic                         eof_o,
    output logic [15:0]                  sat_cnt_o
);

    localparam int SW = IN_WIDTH + 1;
    // One extra bit so the rounding offset can never wrap the sum.
    localparam int RW = IN_WIDTH + 2;
    localparam logic signed [RW-1:0] HALF = RW'((2 ** SHIFT) / 2);
    localparam logic signed [RW-1:0] MAXV = RW'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [RW-1:0] MINV = RW'(-(2 ** (DATA_WIDTH - 1)));
    localparam logic [AW-1:0] LAST = AW'(BIAS_NUM - 1);

    logic signed [BIAS_WIDTH-1:0] bias_q [BIAS_NUM];
    logic [AW-1:0]                idx_q;
    logic [AW-1:0]                idx_d;
    logic [AW-1:0]                sel;
    logic signed [BIAS_WIDTH-1:0] bias_rd;
    logic                         wr_ok;
    logic signed [SW-1:0]         sum_d;
    logic signed [SW-1:0]         s1_sum;
    logic                         s1_v;
    logic [3:0]                   s1_f;
    logic signed [RW-1:0]         r_d;
    logic signed [RW-1:0]         s2_r;
    logic                         s2_v;
    logic [3:0]                   s2_f;
    logic [DATA_WIDTH-1:0]        out_d;
    logic                         sat_d;

    assign sel     = sop_i ? '0 : idx_q;
    assign bias_rd = bias_q[sel];
    assign wr_ok   = bias_wr_i && (int'(bias_addr_i) < BIAS_NUM);
    assign sum_d   = SW'(data_i) + SW'(bias_rd);
    assign r_d     = (RW'(s1_sum) + HALF) >>> SHIFT;

    always_comb begin
        if (BIAS_NUM == 1)
            idx_d = '0;
        else if (sop_i)
            idx_d = AW'(1);
        else if (idx_q == LAST)
            idx_d = '0;
        else
            idx_d = idx_q + AW'(1);
    end

    // ReLU clamp is checked first so it never registers as saturation.
    always_comb begin
        out_d = s2_r[DATA_WIDTH-1:0];
        sat_d = 1'b0;
        if (RELU != 0 && s2_r[RW-1]) begin
            out_d = '0;
        end else if (s2_r > MAXV) begin
            out_d = MAXV[DATA_WIDTH-1:0];
            sat_d = 1'b1;
        end else if (s2_r < MINV) begin
            out_d = MINV[DATA_WIDTH-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BIAS_NUM; i++)
                bias_q[i] <= '0;
        end else if (wr_ok) begin
            bias_q[bias_addr_i] <= bias_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q        <= '0;
            s1_sum       <= '0;
            s1_v         <= 1'b0;
            s1_f         <= '0;
            s2_r         <= '0;
            s2_v         <= 1'b0;
            s2_f         <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            sop_o        <= 1'b0;
            eop_o        <= 1'b0;
            sof_o        <= 1'b0;
            eof_o        <= 1'b0;
            sat_cnt_o    <= '0;
        end else begin
            if (valid_i)
                idx_q <= idx_d;
            s1_sum <= sum_d;
            s1_v   <= valid_i;
            s1_f   <= {sop_i, eop_i, sof_i, eof_i} & {4{valid_i}};
            s2_r   <= r_d;
            s2_v   <= s1_v;
            s2_f   <= s1_f;
            data_valid_o <= s2_v;
            {sop_o, eop_o, sof_o, eof_o} <= s2_f;
            if (s2_v) begin
                data_o <= out_d;
                if (s2_f[1])
                    sat_cnt_o <= {15'b0, sat_d};
                else if (sat_d && sat_cnt_o != 16'hFFFF)
                    sat_cnt_o <= sat_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bias_requant_relu.sv
// Scoreboard bench: two instances (ReLU/16 channels and linear/4 channels)
// share the sample stream; expected outputs are queued with their due cycle.
module tb_bias_requant_relu;

    localparam int IW = 24;
    localparam int DW = 8;
    localparam int BW = 24;

    typedef struct {
        int         due;
        logic [7:0] data;
        logic [3:0] flg;
        logic [15:0] sat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic valid_i = 1'b0;
    logic signed [IW-1:0] data_i = '0;
    logic sop_i = 1'b0, eop_i = 1'b0, sof_i = 1'b0, eof_i = 1'b0;

    logic wr_a = 1'b0;
    logic [3:0] addr_a = '0;
    logic signed [BW-1:0] bdat_a = '0;
    logic wr_b = 1'b0;
    logic [1:0] addr_b = '0;
    logic signed [BW-1:0] bdat_b = '0;

    logic [DW-1:0] d_a, d_b;
    logic dv_a, dv_b;
    logic sop_a, eop_a, sof_a, eof_a;
    logic sop_b, eop_b, sof_b, eof_b;
    logic [15:0] sc_a, sc_b;

    bias_requant_relu #(
        .IN_WIDTH(IW), .DATA_WIDTH(DW), .BIAS_NUM(16),
        .BIAS_WIDTH(BW), .SHIFT(4), .RELU(1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .data_i(data_i),
        .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
        .bias_wr_i(wr_a), .bias_addr_i(addr_a), .bias_data_i(bdat_a),
        .data_o(d_a), .data_valid_o(dv_a),
        .sop_o(sop_a), .eop_o(eop_a), .sof_o(sof_a), .eof_o(eof_a),
        .sat_cnt_o(sc_a)
    );

    bias_requant_relu #(
        .IN_WIDTH(IW), .DATA_WIDTH(DW), .BIAS_NUM(4),
        .BIAS_WIDTH(BW), .SHIFT(4), .RELU(0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .data_i(data_i),
        .sop_i(sop_i), .eop_i(eop_i), .sof_i(sof_i), .eof_i(eof_i),
        .bias_wr_i(wr_b), .bias_addr_i(addr_b), .bias_data_i(bdat_b),
        .data_o(d_b), .data_valid_o(dv_b),
        .sop_o(sop_b), .eop_o(eop_b), .sof_o(sof_b), .eof_o(eof_b),
        .sat_cnt_o(sc_b)
    );

    exp_t qa[$];
    exp_t qb[$];
    int mba[16];
    int mbb[4];
    int idxa = 0, idxb = 0;
    logic [15:0] sata = '0, satb = '0;
    logic [7:0] lasta = '0, lastb = '0;
    logic [15:0] lsata = '0, lsatb = '0;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    task automatic cmp(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input bit has, input exp_t e,
                       input logic dv, input logic [7:0] d,
                       input logic [3:0] f, input logic [15:0] sc);
        cmp({tag, "_valid"}, 32'(dv), 32'(has));
        cmp({tag, "_data"}, 32'(d), 32'(e.data));
        cmp({tag, "_flags"}, 32'(f), 32'(e.flg));
        cmp({tag, "_satcnt"}, 32'(sc), 32'(e.sat));
    endtask

    function automatic void calc(input bit relu, input int d, input int b,
                                 output logic [7:0] o, output bit s);
        longint sum, r;
        sum = longint'(d) + longint'(b);
        r = (sum + 8) >>> 4;
        s = 1'b0;
        if (relu && r < 0) begin
            o = 8'h00;
        end else if (r > 127) begin
            o = 8'h7F;
            s = 1'b1;
        end else if (r < -128) begin
            o = 8'h80;
            s = 1'b1;
        end else begin
            o = 8'(r);
        end
    endfunction

    function automatic logic [15:0] sat_upd(input logic [15:0] c,
                                            input bit sof, input bit s);
        if (sof)
            return s ? 16'd1 : 16'd0;
        if (s && c != 16'hFFFF)
            return c + 16'd1;
        return c;
    endfunction

    task automatic check_outputs();
        exp_t e;
        bit has;
        has = (qa.size() > 0) && (qa[0].due == cyc);
        if (has) e = qa.pop_front();
        else begin e.data = lasta; e.flg = '0; e.sat = lsata; end
        lasta = e.data;
        lsata = e.sat;
        chk("a", has, e, dv_a, d_a, {sop_a, eop_a, sof_a, eof_a}, sc_a);
        has = (qb.size() > 0) && (qb[0].due == cyc);
        if (has) e = qb.pop_front();
        else begin e.data = lastb; e.flg = '0; e.sat = lsatb; end
        lastb = e.data;
        lsatb = e.sat;
        chk("b", has, e, dv_b, d_b, {sop_b, eop_b, sof_b, eof_b}, sc_b);
    endtask

    task automatic step();
        exp_t e;
        logic [7:0] o;
        bit s;
        if (valid_i) begin
            e.due = cyc + 3;
            e.flg = {sop_i, eop_i, sof_i, eof_i};
            calc(1'b1, int'(data_i), mba[sop_i ? 0 : idxa], o, s);
            sata = sat_upd(sata, sof_i, s);
            e.data = o;
            e.sat = sata;
            qa.push_back(e);
            idxa = sop_i ? 1 : (idxa + 1) % 16;
            calc(1'b0, int'(data_i), mbb[sop_i ? 0 : idxb], o, s);
            satb = sat_upd(satb, sof_i, s);
            e.data = o;
            e.sat = satb;
            qb.push_back(e);
            idxb = sop_i ? 1 : (idxb + 1) % 4;
        end
        if (wr_a) mba[addr_a] = int'(bdat_a);
        if (wr_b) mbb[addr_b] = int'(bdat_b);
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic drv(input bit v, input int d, input bit sp = 0,
                       input bit ep = 0, input bit sf = 0, input bit ef = 0);
        valid_i = v;
        data_i = IW'(d);
        sop_i = sp;
        eop_i = ep;
        sof_i = sf;
        eof_i = ef;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 0);
    endtask

    task automatic wrb(input int a, input int v);
        wr_b = 1'b1;
        addr_b = 2'(a);
        bdat_b = BW'(v);
        drv(1'b0, 0);
        wr_b = 1'b0;
    endtask

    task automatic wra(input int a, input int v);
        wr_a = 1'b1;
        addr_a = 4'(a);
        bdat_a = BW'(v);
        drv(1'b0, 0);
        wr_a = 1'b0;
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        foreach (mba[i]) mba[i] = 0;
        foreach (mbb[i]) mbb[i] = 0;
        idxa = 0;
        idxb = 0;
        sata = '0;
        satb = '0;
        lasta = '0;
        lastb = '0;
        lsata = '0;
        lsatb = '0;
    endtask

    initial begin
        exp_t z;
        z.due = 0;
        z.data = '0;
        z.flg = '0;
        z.sat = '0;
        model_reset();
        #1;
        chk("rst_a", 1'b0, z, dv_a, d_a, {sop_a, eop_a, sof_a, eof_a}, sc_a);
        chk("rst_b", 1'b0, z, dv_b, d_b, {sop_b, eop_b, sof_b, eof_b}, sc_b);
        @(negedge clk);
        reset_n = 1'b1;

        // basic path, latency, ReLU, saturation both ways
        drv(1'b1, 160, 1'b1, 1'b0, 1'b1);
        idle(4);
        drv(1'b1, -24);
        drv(1'b1, 4000);
        drv(1'b1, -3000);
        drv(1'b1, -40);
        idle(4);

        // channel bias rotation on the 4-channel instance
        wrb(0, 16);
        wrb(1, 32);
        wrb(2, -16);
        wrb(3, 0);
        drv(1'b1, 0, 1'b1);
        repeat (5) drv(1'b1, 0);
        idle(3);

        // sop realigns the channel index
        drv(1'b1, 0);
        drv(1'b1, 0);
        drv(1'b1, 0, 1'b1);
        drv(1'b1, 0);
        idle(4);

        // bubbles with framing flags and sat counter restart
        drv(1'b1, 4000, 1'b1, 1'b0, 1'b1, 1'b0);
        drv(1'b0, 0);
        drv(1'b1, 0);
        drv(1'b1, 4000);
        drv(1'b0, 0);
        drv(1'b1, -3000, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(4);

        // bias write colliding with its own read
        wrb(0, 0);
        wr_a = 1'b1;
        addr_a = 4'd0;
        bdat_a = BW'(64);
        wr_b = 1'b1;
        addr_b = 2'd0;
        bdat_b = BW'(64);
        drv(1'b1, 0, 1'b1);
        wr_a = 1'b0;
        wr_b = 1'b0;
        drv(1'b1, 0, 1'b1);
        idle(4);

        // reset with samples in flight
        drv(1'b1, 4000, 1'b1, 1'b0, 1'b1);
        drv(1'b1, 160);
        valid_i = 1'b0;
        sop_i = 1'b0;
        sof_i = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("inrst_a", 1'b0, z, dv_a, d_a, {sop_a, eop_a, sof_a, eof_a}, sc_a);
        chk("inrst_b", 1'b0, z, dv_b, d_b, {sop_b, eop_b, sof_b, eof_b}, sc_b);
        idle(2);
        #2;
        reset_n = 1'b1;
        idle(4);
        wra(0, 48);
        wrb(0, 16);
        wrb(1, 32);
        drv(1'b1, 0);
        idle(4);

        cmp("a_queue_drained", 32'(qa.size()), 32'd0);
        cmp("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bias_requant_relu.md
Name: bias_requant_relu

Overview:
- Post-accumulation stage placed directly downstream of the pointwise vector-matrix multiplier.
- Takes wide signed per-output-channel sums. Output channels arrive interleaved per pixel: ch0..chN-1, then the next pixel.
- For each sum it adds a per-channel bias, applies a rounding arithmetic right shift, applies an optional ReLU, and saturates to DATA_WIDTH.
- Produces the narrow activation stream for the next conv layer, with all framing flags kept aligned to the data.

Parameters:
- IN_WIDTH, 24, signed width of data_i (accumulator width of the upstream stage).
- DATA_WIDTH, 8, signed width of data_o.
- BIAS_NUM, 16, number of output channels and bias entries; index wraps at this count.
- BIAS_WIDTH, 24, signed bias width; must be <= IN_WIDTH.
- SHIFT, 4, requantization right shift, 0..IN_WIDTH-1.
- RELU, 1, 1 clamps negative results to 0, 0 passes them through.

Ports:
- clk  in  1  clock.
- reset_n  in  1  async active-low reset.
- valid_i  in  1  data_i qualifier.
- data_i  in  IN_WIDTH  signed accumulated sum.
- sop_i, eop_i, sof_i, eof_i  in  1 each  line/frame markers; meaningful only with valid_i.
- bias_wr_i  in  1  bias table write strobe.
- bias_addr_i  in  $clog2(BIAS_NUM)  bias write index.
- bias_data_i  in  BIAS_WIDTH  signed bias value.
- data_o  out  DATA_WIDTH  signed requantized activation.
- data_valid_o  out  1  data_o qualifier.
- sop_o, eop_o, sof_o, eof_o  out  1 each  delayed markers.
- sat_cnt_o  out  16  saturation events in current frame.

Behaviour:
- One clock domain. Reset is asynchronous, active-low, on reset_n.
- Reset values:
  - all outputs 0;
  - bias table all 0;
  - channel index 0;
  - pipeline valid/flag registers 0;
  - sat_cnt_o 0.
- Bias table:
  - Register file of BIAS_NUM x BIAS_WIDTH, written synchronously when bias_wr_i=1.
  - A read of the entry being written in the same cycle returns the old value.
  - bias_addr_i >= BIAS_NUM: write ignored.
- Channel index (idx):
  - The bias used for a sample is bias[sop_i ? 0 : idx].
  - On valid_i: idx <= (sop_i ? 1 : idx+1), wrapping from BIAS_NUM-1 to 0. With BIAS_NUM=1 idx stays 0.
  - No valid_i: idx holds.
- Pipeline, fixed latency 3 cycles from valid_i to data_valid_o. No backpressure; accepts one sample per cycle, gaps allowed.
  - S1: sum = sext(data_i) + sext(bias) in IN_WIDTH+1 bits. No overflow possible.
  - S2: if SHIFT>0, r = (sum + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic). If SHIFT=0, r = sum.
  - S3 ReLU: if RELU=1 and r<0, out = 0.
  - S3 saturation:
    - r > 2^(DATA_WIDTH-1)-1 gives max;
    - r < -2^(DATA_WIDTH-1) gives min (only reachable with RELU=0);
    - otherwise out = r[DATA_WIDTH-1:0].
  - A ReLU clamp does not count as saturation.
- Flags:
  - sop/eop/sof/eof are each ANDed with valid_i at S1 and delayed identically, so they exit with their sample.
  - data_o holds its last value when data_valid_o=0.
- sat_cnt_o:
  - Updated at S3 output.
  - On a valid output with sof_o=1: sat_cnt_o <= (this sample saturated ? 1 : 0).
  - Otherwise it increments by 1 on each saturated valid output, saturating at 16'hFFFF.
- Reset mid-operation clears in-flight samples; no output is produced for them after reset release.

Test Plan:
- Default params, bias all 0.
  - data_i=160 valid 1 cycle -> data_o=10 with data_valid_o exactly 3 cycles later.
  - data_i=-24 -> 0 (ReLU), sat_cnt_o unchanged.
- Saturation:
  - data_i=4000 -> 127, sat_cnt_o +1.
  - With RELU=0, data_i=-3000 -> -128, sat_cnt_o +1.
  - With RELU=0, data_i=-40 -> -2 ((-32)>>>4).
- Bias rotation: BIAS_NUM=4, RELU=0, biases {16,32,-16,0}, six consecutive valid samples of data_i=0 -> outputs 1,2,-1,0,1,2.
- sop realignment: two valid samples, then a valid sample with sop_i=1 and data_i=0 (biases as above) -> that output=1 (bias[0]); next sample uses bias[1] -> 2.
- Bubbles and flags: valid pattern 1,0,1,1,0,1 with sof on the first sample and eof on the last -> identical data_valid_o pattern delayed by 3 cycles; sof_o/eof_o coincide with the first/last outputs; sat_cnt_o restarts at the sof_o output.
- Reset/write collision:
  - Write bias[0]=64 in the same cycle that bias[0] is consumed with data_i=0 -> output 0 (old bias); next use gives 4.
  - Assert reset_n=0 with 2 samples in flight -> all outputs 0, no data_valid_o after release, idx=0.
